// File: rtl/sram_arb2.sv
// sram_arb2: two-requester arbiter in front of one single-port, byte-writable
// SRAM. Requester 0 is the AXI4-Lite path, requester 1 the stream/BIST port.
// Round-robin with bounded burst locking by default; defining
// SRAM_ARB_FIXED_PRIO_EN makes requester 0 win every tie and removes the
// lock/burst-count logic (m0_lock/m1_lock are then ignored).
// The winning command is registered onto the SRAM pins, and read data is
// steered back to the issuing requester after RD_LATENCY+2 cycles.
module sram_arb2 #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  // requester 0
  input  logic                    m0_req,
  input  logic                    m0_lock,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  // requester 1
  input  logic                    m1_req,
  input  logic                    m1_lock,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  // SRAM macro pins
  output logic                    sram_en,
  output logic [DATA_WIDTH/8-1:0] sram_we,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH-1:0]   sram_rdata
);

  localparam int SW = DATA_WIDTH / 8;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic                  w_gnt0, w_gnt1, w_any, w_gid;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [SW-1:0]         w_wstrb;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Lock inputs have no effect in fixed-priority mode.
  logic w_unused_lock;
  assign w_unused_lock = m0_lock ^ m1_lock;

  // Fixed priority: requester 0 wins whenever it asks.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!ARESET) begin
      w_gnt0 = m0_req;
      w_gnt1 = m1_req & ~m0_req;
    end
  end
`else
  localparam logic [3:0] BMAX = 4'(MAX_BURST);

  logic       r_last;   // id of last granted requester
  logic       r_owner;  // id of current burst holder
  logic [3:0] r_bcnt;   // grants given to owner in the current burst
  logic       w_owner_lock, w_gid_lock;

  assign w_owner_lock = r_owner ? m1_lock : m0_lock;
  assign w_gid_lock   = w_gid   ? m1_lock : m0_lock;

  // Round-robin grant; an owner holding lock keeps the bus against a
  // waiting peer until it has had MAX_BURST grants in a row.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!ARESET) begin
      if (m0_req && !m1_req) begin
        w_gnt0 = 1'b1;
      end else if (m1_req && !m0_req) begin
        w_gnt1 = 1'b1;
      end else if (m0_req && m1_req) begin
        if (w_owner_lock && (r_bcnt < BMAX)) begin
          w_gnt0 = ~r_owner;
          w_gnt1 = r_owner;
        end else begin
          w_gnt0 = r_last;
          w_gnt1 = ~r_last;
        end
      end
    end
  end

  // Arbiter history: last winner, burst owner and saturating burst count.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_bcnt  <= 4'd0;
    end else if (w_any) begin
      r_last <= w_gid;
      if ((w_gid == r_owner) && w_gid_lock) begin
        if (r_bcnt < BMAX) r_bcnt <= r_bcnt + 4'd1;
      end else begin
        r_owner <= w_gid;
        r_bcnt  <= 4'd1;
      end
    end
  end
`endif

  assign w_any   = w_gnt0 | w_gnt1;
  assign w_gid   = w_gnt1;
  assign m0_gnt  = w_gnt0;
  assign m1_gnt  = w_gnt1;

  assign w_we    = w_gid ? m1_we    : m0_we;
  assign w_addr  = w_gid ? m1_addr  : m0_addr;
  assign w_wdata = w_gid ? m1_wdata : m0_wdata;
  assign w_wstrb = w_gid ? m1_wstrb : m0_wstrb;

  // ---------------------------------------------------------------------------
  // SRAM command register
  // ---------------------------------------------------------------------------
  logic                  r_sram_en;
  logic [SW-1:0]         r_sram_we;
  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [DATA_WIDTH-1:0] r_sram_wdata;

  // Launch the granted command onto the pins one cycle after acceptance;
  // address/data hold their last value while idle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_sram_en    <= 1'b0;
      r_sram_we    <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
    end else begin
      r_sram_en <= w_any;
      r_sram_we <= (w_any && w_we) ? w_wstrb : '0;
      if (w_any) begin
        r_sram_addr  <= w_addr;
        r_sram_wdata <= w_wdata;
      end
    end
  end

  assign sram_en    = r_sram_en;
  assign sram_we    = r_sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;

  // ---------------------------------------------------------------------------
  // Read tracking and response routing
  // ---------------------------------------------------------------------------
  // Stage k is occupied k+1 cycles after the grant; the tail lines up with
  // valid sram_rdata.
  logic [RD_LATENCY:0] r_vld_pipe;
  logic [RD_LATENCY:0] r_id_pipe;
  logic                w_rd;

  assign w_rd = w_any & ~w_we;

  // Shift {valid, id} of each accepted read toward the data-return point.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[RD_LATENCY-1:0], w_rd};
      r_id_pipe  <= {r_id_pipe[RD_LATENCY-1:0],  w_gid};
    end
  end

  logic                  r_m0_rvalid, r_m1_rvalid;
  logic [DATA_WIDTH-1:0] r_m0_rdata,  r_m1_rdata;
  logic                  w_ret0, w_ret1;

  assign w_ret0 = r_vld_pipe[RD_LATENCY] & ~r_id_pipe[RD_LATENCY];
  assign w_ret1 = r_vld_pipe[RD_LATENCY] &  r_id_pipe[RD_LATENCY];

  // Capture returning data for the tagged requester only; the other keeps
  // its previous rdata.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= w_ret0;
      r_m1_rvalid <= w_ret1;
      if (w_ret0) r_m0_rdata <= sram_rdata;
      if (w_ret1) r_m1_rdata <= sram_rdata;
    end
  end

  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_sram_arb2.sv
// Bench for sram_arb2: directed scenarios followed by random traffic. A driver
// applies commands and predicts grants, pin values and read responses from an
// abstract model (grant rules + flat reference memory); a separate monitor
// pops predicted read responses whenever an rvalid appears.
module tb_sram_arb2;
  localparam int AW = 10, DW = 32, SW = 4, RL = 1, MB = 4;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b0;
  logic          m0_req = 0, m0_lock = 0, m0_we = 0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [SW-1:0] m0_wstrb = '0;
  logic          m1_req = 0, m1_lock = 0, m1_we = 0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [SW-1:0] m1_wstrb = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          sram_en;
  logic [SW-1:0] sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  always #5 ACLK = ~ACLK;

  sram_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL), .MAX_BURST(MB)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural SRAM macro: byte writes, read data one cycle after en.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge ACLK) begin
    if (sram_en) begin
      if (|sram_we) begin
        for (int b = 0; b < SW; b++)
          if (sram_we[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int checks = 0, errors = 0, cyc = 0;

  typedef struct { logic [DW-1:0] d; int due; } rexp_t;
  rexp_t q0[$], q1[$];
  int            log_id[$];
  logic [DW-1:0] log_d[$];
  int            log_cyc[$];
  int            gseq[$];

  // reference model state
  logic [DW-1:0] refm [0:(1<<AW)-1];
  int            m_last, m_owner, m_cnt;
  logic          pe_en = 1'b0;
  logic [SW-1:0] pe_we;
  logic [AW-1:0] pe_addr;
  logic [DW-1:0] pe_wd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every rvalid must match the oldest prediction for that requester.
  rexp_t mon_e;
  always @(negedge ACLK) begin
    if (m0_rvalid) begin
      log_id.push_back(0); log_d.push_back(m0_rdata); log_cyc.push_back(cyc);
      if (q0.size() == 0) chk("m0_rvalid_unexpected", 1, 0);
      else begin
        mon_e = q0.pop_front();
        chk("m0_rdata", m0_rdata, mon_e.d);
        chk("m0_rvalid_cycle", cyc, mon_e.due);
      end
    end
    if (m1_rvalid) begin
      log_id.push_back(1); log_d.push_back(m1_rdata); log_cyc.push_back(cyc);
      if (q1.size() == 0) chk("m1_rvalid_unexpected", 1, 0);
      else begin
        mon_e = q1.pop_front();
        chk("m1_rdata", m1_rdata, mon_e.d);
        chk("m1_rvalid_cycle", cyc, mon_e.due);
      end
    end
  end

  // One clock cycle: check pins launched last cycle, predict and check this
  // cycle's grant, apply the accepted command to the model.
  task automatic step();
    int eg;
    logic lk, we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [SW-1:0] st;
    @(negedge ACLK);
    chk("sram_en", sram_en, pe_en);
    if (pe_en) begin
      chk("sram_we", sram_we, pe_we);
      chk("sram_addr", sram_addr, pe_addr);
      chk("sram_wdata", sram_wdata, pe_wd);
    end
    eg = -1;
    if (!ARESET) begin
      if (m0_req && !m1_req) eg = 0;
      else if (m1_req && !m0_req) eg = 1;
      else if (m0_req && m1_req) begin
        lk = (m_owner == 0) ? m0_lock : m1_lock;
        eg = (lk && m_cnt < MB) ? m_owner : 1 - m_last;
      end
    end
    chk("m0_gnt", m0_gnt, eg == 0);
    chk("m1_gnt", m1_gnt, eg == 1);
    gseq.push_back(eg);
    pe_en = (eg >= 0);
    pe_we = '0;
    if (eg >= 0) begin
      lk = eg ? m1_lock  : m0_lock;
      we = eg ? m1_we    : m0_we;
      a  = eg ? m1_addr  : m0_addr;
      wd = eg ? m1_wdata : m0_wdata;
      st = eg ? m1_wstrb : m0_wstrb;
      if (eg == m_owner && lk) m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
      else begin m_owner = eg; m_cnt = 1; end
      m_last = eg;
      pe_addr = a;
      pe_wd = wd;
      if (we) begin
        pe_we = st;
        for (int b = 0; b < SW; b++)
          if (st[b]) refm[a][b*8 +: 8] = wd[b*8 +: 8];
      end else if (eg == 0) q0.push_back('{refm[a], cyc + 2 + RL});
      else q1.push_back('{refm[a], cyc + 2 + RL});
    end
    @(posedge ACLK);
    cyc++;
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    #1;
    q0.delete(); q1.delete();
    pe_en = 1'b0; m_last = 1; m_owner = 0; m_cnt = 0;
    chk("rst_sram_en", sram_en, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_wdata", sram_wdata, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    steps(2);
    ARESET = 1'b0;
  endtask

  task automatic cmd0(input logic rq, input logic lk, input logic we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    m0_req = rq; m0_lock = lk; m0_we = we; m0_addr = a; m0_wdata = d; m0_wstrb = s;
  endtask

  task automatic cmd1(input logic rq, input logic lk, input logic we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    m1_req = rq; m1_lock = lk; m1_we = we; m1_addr = a; m1_wdata = d; m1_wstrb = s;
  endtask

  task automatic rnd(output logic rq, output logic lk, output logic we,
                     output logic [AW-1:0] a, output logic [DW-1:0] d, output logic [SW-1:0] s);
    rq = ($urandom_range(0, 3) != 0);
    lk = ($urandom_range(0, 2) == 0);
    we = 1'($urandom_range(0, 1));
    a  = AW'($urandom_range(0, 15));
    d  = $urandom;
    s  = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
  endtask

  initial begin
    int tg;
    for (int i = 0; i < (1 << AW); i++) begin mem[i] = '0; refm[i] = '0; end
    #2;
    do_reset();

    // single read after a write
    log_id.delete(); log_d.delete(); log_cyc.delete();
    cmd0(1, 0, 1, 0, 32'h1, 4'hF); step();
    cmd0(1, 0, 0, 0, 0, 0); step();
    tg = cyc - 1;
    cmd0(0, 0, 0, 0, 0, 0); steps(5);
    chk("t1_rv_count", log_id.size(), 1);
    if (log_id.size() == 1) begin
      chk("t1_rv_id", log_id[0], 0);
      chk("t1_rdata", log_d[0], 32'h1);
      chk("t1_rv_cycle", log_cyc[0], tg + 3);
    end

    // tie-break alternation from reset
    do_reset();
    gseq.delete();
    cmd0(1, 0, 0, 7, 0, 0); cmd1(1, 0, 0, 8, 0, 0);
    steps(6);
    cmd0(0, 0, 0, 0, 0, 0); cmd1(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) chk("tie_seq", gseq[i], i % 2);
    steps(5);

    // burst lock: m1 locks, m0 waits for MAX_BURST grants
    cmd0(1, 0, 1, 20, 32'h5, 4'hF); step();
    cmd0(0, 0, 0, 0, 0, 0);
    gseq.delete();
    cmd0(1, 0, 1, 21, 32'h6, 4'hF); cmd1(1, 1, 1, 22, 32'h7, 4'hF);
    steps(5);
    cmd0(0, 0, 0, 0, 0, 0); cmd1(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) chk("burst_m1", gseq[i], 1);
    chk("burst_m0", gseq[4], 0);
    steps(2);

    // byte strobes
    cmd0(1, 0, 1, 5, 32'hAABBCCDD, 4'hF); step();
    cmd0(1, 0, 1, 5, 32'h11223344, 4'b0101); step();
    cmd0(1, 0, 0, 5, 0, 0); step();
    cmd0(0, 0, 0, 0, 0, 0); steps(5);
    chk("bstrobe_rdata", m0_rdata, 32'hAA22CC44);

    // read tagging
    cmd0(1, 0, 1, 1, 32'h1, 4'hF); step();
    cmd0(1, 0, 1, 2, 32'h2, 4'hF); step();
    cmd0(1, 0, 1, 3, 32'h3, 4'hF); step();
    log_id.delete(); log_d.delete(); log_cyc.delete();
    cmd0(1, 0, 0, 1, 0, 0); step();
    cmd0(0, 0, 0, 0, 0, 0); cmd1(1, 0, 0, 2, 0, 0); step();
    cmd1(0, 0, 0, 0, 0, 0); cmd0(1, 0, 0, 3, 0, 0); step();
    cmd0(0, 0, 0, 0, 0, 0); steps(6);
    chk("tag_count", log_id.size(), 3);
    if (log_id.size() == 3) begin
      chk("tag_id0", log_id[0], 0); chk("tag_d0", log_d[0], 1);
      chk("tag_id1", log_id[1], 1); chk("tag_d1", log_d[1], 2);
      chk("tag_id2", log_id[2], 0); chk("tag_d2", log_d[2], 3);
      chk("tag_cyc1", log_cyc[1], log_cyc[0] + 1);
      chk("tag_cyc2", log_cyc[2], log_cyc[0] + 2);
    end
    chk("tag_m1_hold", m1_rdata, 2);

    // reset one cycle after a read grant
    log_id.delete(); log_d.delete(); log_cyc.delete();
    cmd0(1, 0, 0, 3, 0, 0); step();
    cmd0(0, 0, 0, 0, 0, 0);
    do_reset();
    steps(6);
    chk("rstmid_no_rvalid", log_id.size(), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!m0_req || gseq[gseq.size()-1] == 0) rnd(m0_req, m0_lock, m0_we, m0_addr, m0_wdata, m0_wstrb);
      if (!m1_req || gseq[gseq.size()-1] == 1) rnd(m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_wstrb);
      step();
    end
    cmd0(0, 0, 0, 0, 0, 0); cmd1(0, 0, 0, 0, 0, 0);
    steps(8);
    chk("drain_pending", q0.size() + q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
